// File: rtl/sw_trace_pkg.sv
// sw_trace_pkg: location indices, checker FSM encoding and the benchmark
// control-flow graph shared by the trace checkers.
package sw_trace_pkg;
    localparam logic [3:0] LOC_L0  = 4'd0;
    localparam logic [3:0] LOC_L1  = 4'd1;
    localparam logic [3:0] LOC_L2  = 4'd2;
    localparam logic [3:0] LOC_L3  = 4'd3;
    localparam logic [3:0] LOC_L4  = 4'd4;
    localparam logic [3:0] LOC_L5  = 4'd5;
    localparam logic [3:0] LOC_L6  = 4'd6;
    localparam logic [3:0] LOC_L7  = 4'd7;
    localparam logic [3:0] LOC_L8  = 4'd8;
    localparam logic [3:0] LOC_BAD = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // Guards arrive pre-reduced so the function stays independent of data width.
    function automatic logic legal_edge(input logic [3:0] prev, input logic [3:0] next,
                                        input logic xy_eq, input logic z_zero,
                                        input logic w_zero);
        case (prev)
            LOC_L0:  legal_edge = next == LOC_L1;
            LOC_L1:  legal_edge = next == LOC_L2;
            LOC_L2:  legal_edge = next == (w_zero ? LOC_L5 : LOC_L3);
            LOC_L3:  legal_edge = next == LOC_L4;
            LOC_L4:  legal_edge = next == LOC_L5;
            LOC_L5:  legal_edge = next == (xy_eq ? LOC_L6 : LOC_L1);
            LOC_L6:  legal_edge = next == (z_zero ? LOC_L8 : LOC_L7);
            LOC_L7:  legal_edge = next == LOC_L7;
            LOC_L8:  legal_edge = next == LOC_L8;
            default: legal_edge = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/sw_onehot_enc.sv
// sw_onehot_enc: 9-location one-hot to binary index, LOC_BAD when not one-hot.
module sw_onehot_enc
    import sw_trace_pkg::*;
(
    input  logic [8:0] oh_i,
    output logic [3:0] idx_o,
    output logic       valid_o
);
    logic [3:0] idx;

    always_comb begin
        idx = LOC_BAD;
        for (int i = 0; i < 9; i++)
            if (oh_i[i]) idx = 4'(i);
    end

    assign valid_o = $onehot(oh_i);
    assign idx_o   = valid_o ? idx : LOC_BAD;
endmodule

// File: rtl/sw_loc_trace_checker.sv
// sw_loc_trace_checker: observes a one-hot program-location trace, checks CFG
// edges and data guards, counts steps/back-edges and latches sticky errors.
module sw_loc_trace_checker
    import sw_trace_pkg::*;
#(
    parameter int W          = 3,
    parameter int STEP_W     = 8,
    parameter int LOOP_W     = 4,
    parameter int LOOP_BOUND = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loc_valid,
    input  logic [8:0]        loc_oh,
    input  logic [W-1:0]      x,
    input  logic [W-1:0]      y,
    input  logic [W-1:0]      z,
    input  logic [W-1:0]      w,
    output logic [3:0]        loc_idx,
    output logic [1:0]        state,
    output logic              prop_ok,
    output logic              onehot_err,
    output logic              trans_err,
    output logic              bound_err,
    output logic [LOOP_W-1:0] loop_cnt,
    output logic [STEP_W-1:0] steps
);
    localparam logic [LOOP_W-1:0] BOUND = LOOP_W'(LOOP_BOUND);

    state_e              state_q, state_d;
    logic [3:0]          loc_idx_q, loc_idx_d, p_idx_q, p_idx_d, enc_idx;
    logic [W-1:0]        p_x_q, p_x_d, p_y_q, p_y_d, p_z_q, p_z_d, p_w_q, p_w_d;
    logic                prop_ok_q, prop_ok_d, onehot_err_q, onehot_err_d;
    logic                trans_err_q, trans_err_d, bound_err_q, bound_err_d;
    logic [LOOP_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                enc_valid, legal, back, chk_fail;

    sw_onehot_enc u_enc (
        .oh_i    (loc_oh),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign legal = legal_edge(p_idx_q, enc_idx, p_x_q == p_y_q, p_z_q == '0, p_w_q == '0);
    assign back  = legal && state_q != ST_IDLE && p_idx_q == LOC_L5 && enc_idx == LOC_L1;
    // ERROR makes no further edge checks; IDLE only accepts L0 as the entry.
    assign chk_fail = state_q == ST_IDLE ? enc_idx != LOC_L0 : state_q != ST_ERROR && !legal;

    always_comb begin
        state_d      = state_q;
        loc_idx_d    = loc_idx_q;
        p_idx_d      = p_idx_q;
        p_x_d        = p_x_q;
        p_y_d        = p_y_q;
        p_z_d        = p_z_q;
        p_w_d        = p_w_q;
        prop_ok_d    = prop_ok_q;
        onehot_err_d = onehot_err_q;
        trans_err_d  = trans_err_q;
        loop_cnt_d   = loop_cnt_q;
        steps_d      = steps_q == '1 ? steps_q : steps_q + 1'b1;
        if (!loc_valid) begin
            steps_d = steps_q;
        end else begin
            loc_idx_d = enc_idx;
            p_idx_d   = enc_idx;
            p_x_d     = x;
            p_y_d     = y;
            p_z_d     = z;
            p_w_d     = w;
            if (!enc_valid) begin
                onehot_err_d = 1'b1;
                state_d      = ST_ERROR;
            end else begin
                prop_ok_d   = prop_ok_q && enc_idx != LOC_L7;
                trans_err_d = trans_err_q || chk_fail;
                loop_cnt_d  = back && loop_cnt_q != '1 ? loop_cnt_q + 1'b1 : loop_cnt_q;
                state_d     = chk_fail ? ST_ERROR :
                              state_q == ST_IDLE ? ST_RUN :
                              state_q == ST_ERROR ? ST_ERROR :
                              enc_idx >= LOC_L7 ? ST_DONE : ST_RUN;
            end
        end
        bound_err_d = bound_err_q || loop_cnt_d > BOUND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            loc_idx_q    <= LOC_L0;
            p_idx_q      <= LOC_L0;
            p_x_q        <= '0;
            p_y_q        <= '0;
            p_z_q        <= '0;
            p_w_q        <= '0;
            prop_ok_q    <= 1'b1;
            onehot_err_q <= 1'b0;
            trans_err_q  <= 1'b0;
            bound_err_q  <= 1'b0;
            loop_cnt_q   <= '0;
            steps_q      <= '0;
        end else begin
            state_q      <= state_d;
            loc_idx_q    <= loc_idx_d;
            p_idx_q      <= p_idx_d;
            p_x_q        <= p_x_d;
            p_y_q        <= p_y_d;
            p_z_q        <= p_z_d;
            p_w_q        <= p_w_d;
            prop_ok_q    <= prop_ok_d;
            onehot_err_q <= onehot_err_d;
            trans_err_q  <= trans_err_d;
            bound_err_q  <= bound_err_d;
            loop_cnt_q   <= loop_cnt_d;
            steps_q      <= steps_d;
        end
    end

    assign state      = state_q;
    assign loc_idx    = loc_idx_q;
    assign prop_ok    = prop_ok_q;
    assign onehot_err = onehot_err_q;
    assign trans_err  = trans_err_q;
    assign bound_err  = bound_err_q;
    assign loop_cnt   = loop_cnt_q;
    assign steps      = steps_q;
endmodule

// File: tb/tb_sw_loc_trace_checker.sv
// tb_sw_loc_trace_checker: directed traces against a successor-table model of
// the benchmark program, plus literal expectations at the end of each trace.
module tb_sw_loc_trace_checker;
    logic       clk = 1'b0, rst_n = 1'b0, loc_valid = 1'b0;
    logic [8:0] loc_oh = '0;
    logic [2:0] x = '0, y = '0, z = '0, w = '0;
    logic [3:0] loc_idx, loop_cnt;
    logic [1:0] state;
    logic       prop_ok, onehot_err, trans_err, bound_err;
    logic [7:0] steps;

    int errors = 0, checks = 0;
    int m_state, m_idx, m_prop, m_oh, m_tr, m_bd, m_loop, m_steps;
    int m_pidx, m_px, m_py, m_pz, m_pw;

    sw_loc_trace_checker #(.W(3), .STEP_W(8), .LOOP_W(4), .LOOP_BOUND(8)) dut (
        .clk(clk), .rst_n(rst_n), .loc_valid(loc_valid), .loc_oh(loc_oh),
        .x(x), .y(y), .z(z), .w(w), .loc_idx(loc_idx), .state(state),
        .prop_ok(prop_ok), .onehot_err(onehot_err), .trans_err(trans_err),
        .bound_err(bound_err), .loop_cnt(loop_cnt), .steps(steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // The program is deterministic: given the source and its data there is exactly one successor.
    function automatic int succ(input int p, input int px, input int py, input int pz, input int pw);
        case (p)
            0: return 1;
            1: return 2;
            2: return pw != 0 ? 3 : 5;
            3: return 4;
            4: return 5;
            5: return px != py ? 1 : 6;
            6: return pz != 0 ? 7 : 8;
            7: return 7;
            8: return 8;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_prop = 1; m_oh = 0; m_tr = 0; m_bd = 0;
        m_loop = 0; m_steps = 0; m_pidx = 0; m_px = 0; m_py = 0; m_pz = 0; m_pw = 0;
    endtask

    task automatic model_step(input logic [8:0] oh, input int xv, input int yv, input int zv, input int wv);
        int n = 0, idx = 15;
        bit ok;
        for (int i = 0; i < 9; i++) if (oh[i]) begin n++; idx = i; end
        if (n != 1) idx = 15;
        m_steps = m_steps < 255 ? m_steps + 1 : 255;
        if (n != 1) begin
            m_oh = 1;
            m_state = 3;
        end else begin
            ok = idx == succ(m_pidx, m_px, m_py, m_pz, m_pw);
            if (idx == 7) m_prop = 0;
            if (m_state == 0) begin
                if (idx == 0) m_state = 1;
                else begin m_tr = 1; m_state = 3; end
            end else begin
                if (ok && m_pidx == 5 && idx == 1) begin
                    m_loop = m_loop < 15 ? m_loop + 1 : 15;
                    if (m_loop > 8) m_bd = 1;
                end
                if (m_state != 3) begin
                    if (!ok) begin m_tr = 1; m_state = 3; end
                    else if (idx >= 7) m_state = 2;
                end
            end
        end
        m_idx = idx; m_pidx = idx; m_px = xv; m_py = yv; m_pz = zv; m_pw = wv;
    endtask

    always @(negedge clk) begin
        chk("state", state, m_state);
        chk("loc_idx", loc_idx, m_idx);
        chk("prop_ok", prop_ok, m_prop);
        chk("onehot_err", onehot_err, m_oh);
        chk("trans_err", trans_err, m_tr);
        chk("bound_err", bound_err, m_bd);
        chk("loop_cnt", loop_cnt, m_loop);
        chk("steps", steps, m_steps);
    end

    task automatic step(input int loc, input int xv = 0, input int yv = 0, input int zv = 0, input int wv = 0);
        logic [8:0] oh;
        oh = '0;
        oh[loc] = 1'b1;
        raw_step(oh, xv, yv, zv, wv);
    endtask

    task automatic raw_step(input logic [8:0] oh, input int xv, input int yv, input int zv, input int wv);
        @(negedge clk);
        loc_oh = oh; x = 3'(xv); y = 3'(yv); z = 3'(zv); w = 3'(wv);
        loc_valid = 1'b1;
        @(posedge clk);
        model_step(oh, xv, yv, zv, wv);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            loc_valid = 1'b0;
            loc_oh = 9'h1FF; x = 3'd7; y = 3'd0; z = 3'd5; w = 3'd0;
        end
    endtask

    task automatic lit(input string t, input int st, input int idx, input int pr, input int oe,
                       input int te, input int be, input int lp, input int sp);
        @(negedge clk);
        loc_valid = 1'b0;
        #1;
        chk({t, ".state"}, state, st);
        chk({t, ".loc_idx"}, loc_idx, idx);
        chk({t, ".prop_ok"}, prop_ok, pr);
        chk({t, ".onehot_err"}, onehot_err, oe);
        chk({t, ".trans_err"}, trans_err, te);
        chk({t, ".bound_err"}, bound_err, be);
        chk({t, ".loop_cnt"}, loop_cnt, lp);
        chk({t, ".steps"}, steps, sp);
    endtask

    // Reset is dropped between edges so its asynchronous effect is observed directly.
    task automatic do_reset(input string t);
        @(negedge clk);
        loc_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk({t, ".rst_state"}, state, 0);
        chk({t, ".rst_loc_idx"}, loc_idx, 0);
        chk({t, ".rst_prop_ok"}, prop_ok, 1);
        chk({t, ".rst_errs"}, {onehot_err, trans_err, bound_err}, 0);
        chk({t, ".rst_loop_cnt"}, loop_cnt, 0);
        chk({t, ".rst_steps"}, steps, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset("init");
        // Nominal path with a three-cycle idle gap mid-trace.
        step(0); step(1); step(2, 0, 0, 0, 1); step(3);
        gap(3);
        step(4); step(5, 2, 2); step(6, 0, 0, 0); step(8);
        lit("nominal", 2, 8, 1, 0, 0, 0, 0, 8);
        gap(3);
        lit("nominal_gap", 2, 8, 1, 0, 0, 0, 0, 8);
        step(7);
        lit("done_exit", 3, 7, 0, 0, 1, 0, 0, 9);

        do_reset("fail");
        step(0); step(1); step(2, 0, 0, 0, 0); step(5, 1, 1); step(6, 0, 0, 3); step(7);
        lit("failure", 2, 7, 0, 0, 0, 0, 0, 6);

        do_reset("guard");
        step(0); step(1); step(2, 0, 0, 0, 0); step(3);
        lit("guard", 3, 3, 1, 0, 1, 0, 0, 4);
        step(4); step(5);
        lit("guard_more", 3, 5, 1, 0, 1, 0, 0, 6);

        do_reset("bound");
        step(0); step(1);
        repeat (9) begin step(2, 0, 0, 0, 0); step(5, 1, 2); step(1); end
        lit("bound9", 1, 1, 1, 0, 0, 1, 9, 29);
        repeat (20) begin step(2, 0, 0, 0, 0); step(5, 1, 2); step(1); end
        lit("bound_sat", 1, 1, 1, 0, 0, 1, 15, 89);

        do_reset("onehot");
        step(0); step(1); step(2, 0, 0, 0, 1);
        raw_step(9'b000000110, 0, 0, 0, 0);
        lit("onehot", 3, 15, 1, 1, 0, 0, 0, 4);

        do_reset("idle_l1");
        step(1);
        lit("idle_l1", 3, 1, 1, 0, 1, 0, 0, 1);

        do_reset("async");
        step(0); step(1); step(2, 0, 0, 0, 1);
        do_reset("async_mid");
        step(0);
        lit("after_async", 1, 0, 1, 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
